load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/half/word/double accesses to a doubleword data memory,
// doing read-modify-write for sub-doubleword stores and extending load results.
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | memory read of addressed doubleword into read buffer
//   WRITE  | one-cycle write of merged doubleword
//   RESP   | one-cycle completion pulse
module load_store_unit #(
  parameter int BITS  = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [BITS-1:0]          req_addr,
  input  logic [BITS-1:0]          req_wdata,
  output logic                     resp_valid,
  output logic [BITS-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic [$clog2(DEPTH)-1:0] mem_endr,
  output logic                     mem_we,
  output logic [BITS-1:0]          mem_din,
  input  logic [BITS-1:0]          mem_dout
);

  localparam int IW = $clog2(DEPTH);
  localparam int AW = IW + 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t state, state_nxt;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [BITS-1:0] wdata_q;
  logic            err_q;
  logic [BITS-1:0] rbuf;

  logic            misalign, illegal, accept;
  logic [5:0]      shamt;
  logic [BITS-1:0] smask, wmask, merged, shifted, load_data;

  // Address bits above the memory window wrap and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[BITS-1:AW];

  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
    illegal = (req_funct3 == 3'b111) | (req_we & req_funct3[2]) | misalign;
  end

  assign accept   = req_valid && req_ready;
  assign mem_endr = addr_q[AW-1:3];
  assign shamt    = {addr_q[2:0], 3'b000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rbuf    <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        err_q   <= illegal;
      end
      if (state == ACCESS) rbuf <= mem_dout;
    end
  end

  always_comb begin
    smask = '1;
    case (f3_q[1:0])
      2'd0:    smask = {{(BITS-8){1'b0}}, 8'hFF};
      2'd1:    smask = {{(BITS-16){1'b0}}, 16'hFFFF};
      2'd2:    smask = {{(BITS-32){1'b0}}, 32'hFFFF_FFFF};
      default: smask = '1;
    endcase
    wmask   = smask << shamt;
    merged  = (rbuf & ~wmask) | ((wdata_q << shamt) & wmask);
    shifted = rbuf >> shamt;
    case (f3_q)
      3'b000:  load_data = {{(BITS-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(BITS-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{(BITS-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_data = {{(BITS-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(BITS-16){1'b0}}, shifted[15:0]};
      3'b110:  load_data = {{(BITS-32){1'b0}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_din    = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = illegal ? RESP : ACCESS;
      end
      ACCESS: state_nxt = we_q ? WRITE : RESP;
      WRITE: begin
        mem_we    = 1'b1;
        mem_din   = merged;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) resp_rdata = load_data;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single requests against a
// behavioural doubleword memory, plus reset-in-WRITE and held-request sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [4:0]  mem_endr;
  logic        mem_we;
  logic [63:0] mem_din, mem_dout;

  logic [63:0] mem [32];

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.BITS(64), .DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_endr   (mem_endr),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_endr];
  always @(posedge clk) if (mem_we) mem[mem_endr] = mem_din;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    int          idx;
    logic [63:0] exp_mem;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          lat = 0;
    int          wes = 0;
    logic        got = 1'b0;
    logic        bad_idle = 1'b0;
    logic        er = 1'b0;
    logic [63:0] rd = '0;
    logic [63:0] din_s = '0;
    logic [4:0]  endr_s = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    check({v.name, " ready"}, {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_we) begin
        wes++;
        din_s  = mem_din;
        endr_s = mem_endr;
      end
      if (resp_valid) begin
        got = 1'b1; lat = c; rd = resp_rdata; er = resp_err;
      end else if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
        bad_idle = 1'b1;
      end
    end
    check({v.name, " resp_seen"}, {63'd0, got}, 64'd1);
    check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({v.name, " rdata"}, rd, v.exp_rdata);
    check({v.name, " err"}, {63'd0, er}, {63'd0, v.exp_err});
    check({v.name, " we_pulses"}, 64'(wes), 64'(v.exp_wes));
    check({v.name, " quiet_outputs"}, {63'd0, bad_idle}, 64'd0);
    check({v.name, " mem"}, mem[v.idx], v.exp_mem);
    if (v.exp_wes == 1) begin
      check({v.name, " mem_endr"}, {59'd0, endr_s}, 64'(v.idx));
      check({v.name, " mem_din"}, din_s, v.exp_mem);
    end
  endtask

  initial begin
    vecs[0]  = '{"LB08",   1'b0, 3'b000, 64'h08,  64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2, 0, 1, 64'h1122_3344_5566_7788};
    vecs[1]  = '{"LBU08",  1'b0, 3'b100, 64'h08,  64'h0, 64'h88,                  1'b0, 2, 0, 1, 64'h1122_3344_5566_7788};
    vecs[2]  = '{"LH0E",   1'b0, 3'b001, 64'h0E,  64'h0, 64'h1122,                1'b0, 2, 0, 1, 64'h1122_3344_5566_7788};
    vecs[3]  = '{"LW0C",   1'b0, 3'b010, 64'h0C,  64'h0, 64'h1122_3344,           1'b0, 2, 0, 1, 64'h1122_3344_5566_7788};
    vecs[4]  = '{"LD08",   1'b0, 3'b011, 64'h08,  64'h0, 64'h1122_3344_5566_7788, 1'b0, 2, 0, 1, 64'h1122_3344_5566_7788};
    vecs[5]  = '{"SH0A",   1'b1, 3'b001, 64'h0A,  64'hABCD, 64'h0,                1'b0, 3, 1, 1, 64'h1122_3344_ABCD_7788};
    vecs[6]  = '{"LH0A",   1'b0, 3'b001, 64'h0A,  64'h0, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0, 2, 0, 1, 64'h1122_3344_ABCD_7788};
    vecs[7]  = '{"LHU0A",  1'b0, 3'b101, 64'h0A,  64'h0, 64'hABCD,                1'b0, 2, 0, 1, 64'h1122_3344_ABCD_7788};
    vecs[8]  = '{"LW06",   1'b0, 3'b010, 64'h06,  64'h0, 64'h0,                   1'b1, 1, 0, 1, 64'h1122_3344_ABCD_7788};
    vecs[9]  = '{"SBU08",  1'b1, 3'b100, 64'h08,  64'hFF, 64'h0,                  1'b1, 1, 0, 1, 64'h1122_3344_ABCD_7788};
    vecs[10] = '{"F3_111", 1'b0, 3'b111, 64'h08,  64'h0, 64'h0,                   1'b1, 1, 0, 1, 64'h1122_3344_ABCD_7788};
    vecs[11] = '{"LD0C",   1'b0, 3'b011, 64'h0C,  64'h0, 64'h0,                   1'b1, 1, 0, 1, 64'h1122_3344_ABCD_7788};
    vecs[12] = '{"SD1F8",  1'b1, 3'b011, 64'h1F8, 64'hDEAD_BEEF_0000_0000, 64'h0, 1'b0, 3, 1, 31, 64'hDEAD_BEEF_0000_0000};
    vecs[13] = '{"LW10",   1'b0, 3'b010, 64'h10,  64'h0, 64'hFFFF_FFFF_F0E0_D0C0, 1'b0, 2, 0, 2, 64'h8000_0000_F0E0_D0C0};
    vecs[14] = '{"LWU14",  1'b0, 3'b110, 64'h14,  64'h0, 64'h8000_0000,           1'b0, 2, 0, 2, 64'h8000_0000_F0E0_D0C0};
    vecs[15] = '{"LW14",   1'b0, 3'b010, 64'h14,  64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0, 2, 0, 2, 64'h8000_0000_F0E0_D0C0};
    vecs[16] = '{"SB13",   1'b1, 3'b000, 64'h13,  64'h1234, 64'h0,                1'b0, 3, 1, 2, 64'h8000_0000_34E0_D0C0};
    vecs[17] = '{"SW110",  1'b1, 3'b010, 64'h110, 64'hFFFF_FFFF_1122_3344, 64'h0, 1'b0, 3, 1, 2, 64'h8000_0000_1122_3344};
    vecs[18] = '{"LB17",   1'b0, 3'b000, 64'h17,  64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 0, 2, 64'h8000_0000_1122_3344};
    vecs[19] = '{"SH0B",   1'b1, 3'b001, 64'h0B,  64'h5A5A, 64'h0,                1'b1, 1, 0, 1, 64'h1122_3344_ABCD_7788};
    vecs[20] = '{"LD1F8",  1'b0, 3'b011, 64'h1F8, 64'h0, 64'hDEAD_BEEF_0000_0000, 1'b0, 2, 0, 31, 64'hDEAD_BEEF_0000_0000};

    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    mem[1] = 64'h1122_3344_5566_7788;
    mem[2] = 64'h8000_0000_F0E0_D0C0;
    mem[3] = 64'h5555_5555_5555_5555;

    // Reset with a request pending: nothing may be accepted.
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011;
    req_addr = 64'h08; req_wdata = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", {63'd0, req_ready}, 64'd1);
    check("rst resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst resp_err", {63'd0, resp_err}, 64'd0);
    check("rst resp_rdata", resp_rdata, 64'd0);
    check("rst mem_we", {63'd0, mem_we}, 64'd0);
    check("rst mem_din", mem_din, 64'd0);
    check("rst mem_endr", {59'd0, mem_endr}, 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst ready", {63'd0, req_ready}, 64'd1);
    check("post_rst resp_valid", {63'd0, resp_valid}, 64'd0);

    for (int i = 0; i < 21; i++) run_vec(vecs[i]);

    // Reset arriving while the write is being presented.
    begin
      logic seen = 1'b0;
      logic resp_after = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
      req_addr = 64'h18; req_wdata = 64'h0123_4567_89AB_CDEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        @(negedge clk);
        if (mem_we) seen = 1'b1;
      end
      check("rstw write_seen", {63'd0, seen}, 64'd1);
      reset = 1'b1;
      #1;
      check("rstw mem_we", {63'd0, mem_we}, 64'd0);
      check("rstw req_ready", {63'd0, req_ready}, 64'd1);
      check("rstw mem_din", mem_din, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (resp_valid) resp_after = 1'b1;
      end
      check("rstw mem_unchanged", mem[3], 64'h5555_5555_5555_5555);
      check("rstw no_resp", {63'd0, resp_after}, 64'd0);
    end

    // Request held valid through a store; the follow-up load waits for IDLE.
    begin
      logic rdy [9];
      logic rv  [9];
      logic [63:0] rdat [9];
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 64'h20; req_wdata = 64'h77;
      check("hold ready0", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        rdy[c] = req_ready; rv[c] = resp_valid; rdat[c] = resp_rdata;
        if (c == 3) begin
          req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h20; req_wdata = 64'h0;
        end
        if (c == 5) req_valid = 1'b0;
      end
      check("hold resp_pattern", {56'd0, rv[1], rv[2], rv[3], rv[4], rv[5], rv[6], rv[7], rv[8]},
            {56'd0, 8'b0010_0100});
      check("hold ready_pattern", {56'd0, rdy[1], rdy[2], rdy[3], rdy[4], rdy[5], rdy[6], rdy[7], rdy[8]},
            {56'd0, 8'b0001_0011});
      check("hold store_rdata", rdat[3], 64'd0);
      check("hold load_rdata", rdat[6], 64'h77);
      check("hold mem4", mem[4], 64'h77);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
